sext_serial_rx: RTL and testbench

//  Receiver end of the signed/unsigned value path: accepts LSB-first serial words of
//  1..IN_W_MAX bits, each tagged signed or unsigned. Rebuilds each word and sign- or

---
 rtl/sext_rx_pkg.sv | 25 ++
 rtl/sext_fill.sv | 17 +
 rtl/sext_serial_rx.sv | 127 ++++++++++++
 tb/tb_sext_serial_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sext_rx_pkg.sv
// Shared types and the extension rule for the serial sign/zero-extending receiver.
package sext_rx_pkg;

  localparam int SEXT_IN_W  = 8;
  localparam int SEXT_OUT_W = 16;

  typedef enum logic {COLLECT = 1'b0, STALL = 1'b1} rx_state_t;

  // Keep bits[n-1:0]; fill everything above with bits[n-1] when sgn, else zero.
  function automatic logic [SEXT_OUT_W-1:0] sext(input logic [SEXT_IN_W-1:0] bits,
                                                 input int n, input logic sgn);
    logic [SEXT_OUT_W-1:0] r;
    logic msb;
    msb = 1'b0;
    for (int i = 0; i < SEXT_IN_W; i++) begin
      if (i + 1 == n) msb = bits[i];
    end
    r = {SEXT_OUT_W{sgn & msb}};
    for (int i = 0; i < SEXT_IN_W; i++) begin
      if (i < n) r[i] = bits[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sext_fill.sv
// Combinational extender: widens the assembled serial word to the output width.
module sext_fill
  import sext_rx_pkg::*;
#(
  parameter int IN_W_MAX = SEXT_IN_W,
  parameter int OUT_W    = SEXT_OUT_W,
  parameter int WW       = $clog2(IN_W_MAX + 1)
) (
  input  logic [IN_W_MAX-1:0] bits,
  input  logic [WW-1:0]       n,
  input  logic                sgn,
  output logic [OUT_W-1:0]    word
);

  assign word = sext(bits, int'(n), sgn);

endmodule

// File: rtl/sext_serial_rx.sv
// LSB-first serial word receiver with sign/zero extension and a one-word output register.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid, once high,
// holds with stable payload until that transfer; ready may change freely.
module sext_serial_rx
  import sext_rx_pkg::*;
#(
  parameter int IN_W_MAX = SEXT_IN_W,
  parameter int OUT_W    = SEXT_OUT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic                             s_bit,
  input  logic                             s_last,
  input  logic                             s_signed,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [OUT_W-1:0]                 m_data,
  output logic [$clog2(IN_W_MAX+1)-1:0]    m_width,
  output logic                             m_ovf
);

  localparam int WW = $clog2(IN_W_MAX + 1);
  localparam int CW = $clog2(IN_W_MAX + 2);

  rx_state_t           state, state_nxt;
  logic [CW-1:0]       cnt, asm_cnt;
  logic [IN_W_MAX-1:0] sreg, asm_bits;
  logic                sgn, asm_sgn, ovf_pend, asm_ovf;
  logic [WW-1:0]       n;
  logic [OUT_W-1:0]    fill_word;
  logic                bit_xfer, out_xfer, out_free, load, capture;

  assign s_ready  = (state == COLLECT);
  assign bit_xfer = s_valid && s_ready;
  assign out_xfer = m_valid && m_ready;
  assign out_free = !m_valid || m_ready;

  // Word as it stands after this cycle's bit; in STALL no bit arrives, so it is the held word.
  always_comb begin
    asm_bits = sreg;
    asm_cnt  = cnt;
    asm_sgn  = sgn;
    asm_ovf  = ovf_pend;
    if (bit_xfer) begin
      if (cnt < CW'(IN_W_MAX)) asm_bits = sreg | (IN_W_MAX'(s_bit) << cnt);
      else                     asm_ovf  = 1'b1;
      if (cnt != CW'(IN_W_MAX + 1)) asm_cnt = cnt + CW'(1);
      if (cnt == '0) asm_sgn = s_signed;
    end
    n = (asm_cnt > CW'(IN_W_MAX)) ? WW'(IN_W_MAX) : WW'(asm_cnt);
  end

  sext_fill #(.IN_W_MAX(IN_W_MAX), .OUT_W(OUT_W), .WW(WW)) u_fill (
    .bits (asm_bits),
    .n    (n),
    .sgn  (asm_sgn),
    .word (fill_word)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      COLLECT: begin
        if (bit_xfer && s_last) begin
          if (out_free) begin
            load = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = STALL;
          end
        end else if (bit_xfer) begin
          capture = 1'b1;
        end
      end
      STALL: begin
        if (m_ready) begin
          load      = 1'b1;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sreg     <= '0;
      sgn      <= 1'b0;
      ovf_pend <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_width  <= '0;
      m_ovf    <= 1'b0;
    end else begin
      if (load) begin
        cnt      <= '0;
        sreg     <= '0;
        sgn      <= 1'b0;
        ovf_pend <= 1'b0;
      end else if (capture) begin
        cnt      <= asm_cnt;
        sreg     <= asm_bits;
        sgn      <= asm_sgn;
        ovf_pend <= asm_ovf;
      end
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= fill_word;
        m_width <= n;
        m_ovf   <= asm_ovf;
      end else if (out_xfer) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sext_serial_rx.sv
// Directed bench for sext_serial_rx: extension rules, stall ordering, overflow and reset.
module tb_sext_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_bit, s_last, s_signed;
  logic        m_valid, m_ready, m_ovf;
  logic [15:0] m_data;
  logic [3:0]  m_width;
  int          n_chk = 0;
  int          n_fail = 0;

  sext_serial_rx #(.IN_W_MAX(8), .OUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_bit(s_bit), .s_last(s_last), .s_signed(s_signed),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_width(m_width), .m_ovf(m_ovf)
  );

  always #5 clk = ~clk;

  // Presents one bit from a falling edge and returns 1 time unit after the accepting edge.
  task automatic send_bit(input logic b, input logic last, input logic sg);
    int t;
    t = 0;
    @(negedge clk);
    s_valid = 1'b1; s_bit = b; s_last = last; s_signed = sg;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_bit_timeout: s_ready=%b required 1", s_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // s_signed is inverted after the first bit: only the first bit's tag may matter.
  task automatic send_word(input logic [15:0] bits, input int nbits, input logic sg);
    for (int i = 0; i < nbits; i++) send_bit(bits[i], i == nbits - 1, (i == 0) ? sg : ~sg);
  endtask

  task automatic drain();
    @(negedge clk);
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_last = 1'b0; s_signed = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %b need 1", s_ready); end
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b need 0", m_valid); end
    n_chk++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL rst_m_data: got %h need 0000", m_data); end
    n_chk++; if (m_width !== 4'd0) begin n_fail++; $display("FAIL rst_m_width: got %0d need 0", m_width); end
    n_chk++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_m_ovf: got %b need 0", m_ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_signed_one_bit();
    drain();
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL t1_idle_valid: got %b need 0", m_valid); end
    send_word(16'h0001, 1, 1'b1);
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL t1_latency_valid: got %b need 1", m_valid); end
    n_chk++; if (m_data !== 16'hFFFF) begin n_fail++; $display("FAIL t1_data: got %h need ffff", m_data); end
    n_chk++; if (m_width !== 4'd1) begin n_fail++; $display("FAIL t1_width: got %0d need 1", m_width); end
    n_chk++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL t1_ovf: got %b need 0", m_ovf); end
    @(posedge clk); #1;
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_drop: got %b need 0", m_valid); end
  endtask

  task automatic test_unsigned();
    drain();
    send_word(16'h0001, 1, 1'b0);
    n_chk++; if (m_data !== 16'h0001) begin n_fail++; $display("FAIL t2_u1: got %h need 0001", m_data); end
    send_word(16'h0003, 2, 1'b0);
    n_chk++; if (m_data !== 16'h0003) begin n_fail++; $display("FAIL t2_u2: got %h need 0003", m_data); end
    n_chk++; if (m_width !== 4'd2) begin n_fail++; $display("FAIL t2_u2_width: got %0d need 2", m_width); end
    send_word(16'h00FF, 8, 1'b0);
    n_chk++; if (m_data !== 16'h00FF) begin n_fail++; $display("FAIL t2_u8: got %h need 00ff", m_data); end
  endtask

  task automatic test_signed_two_bit();
    drain();
    send_word(16'h0001, 2, 1'b1);
    n_chk++; if (m_data !== 16'h0001) begin n_fail++; $display("FAIL t3_s01: got %h need 0001", m_data); end
    send_word(16'h0002, 2, 1'b1);
    n_chk++; if (m_data !== 16'hFFFE) begin n_fail++; $display("FAIL t3_s10: got %h need fffe", m_data); end
  endtask

  task automatic test_stall();
    drain();
    m_ready = 1'b0;
    send_word(16'h0005, 3, 1'b0);
    n_chk++; if (m_data !== 16'h0005) begin n_fail++; $display("FAIL t4_first: got %h need 0005", m_data); end
    send_word(16'h0003, 2, 1'b0);
    n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL t4_stall_ready: got %b need 0", s_ready); end
    n_chk++; if (m_data !== 16'h0005) begin n_fail++; $display("FAIL t4_hold_data: got %h need 0005", m_data); end
    @(negedge clk);
    s_valid = 1'b1; s_bit = 1'b1; s_last = 1'b1; s_signed = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (m_data !== 16'h0005) begin n_fail++; $display("FAIL t4_ignored_bit: got %h need 0005", m_data); end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL t4_second_valid: got %b need 1", m_valid); end
    n_chk++; if (m_data !== 16'h0003) begin n_fail++; $display("FAIL t4_second: got %h need 0003", m_data); end
    n_chk++; if (m_width !== 4'd2) begin n_fail++; $display("FAIL t4_second_width: got %0d need 2", m_width); end
    n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready_back: got %b need 1", s_ready); end
    @(posedge clk); #1;
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL t4_drained: got %b need 0", m_valid); end
  endtask

  task automatic test_overflow();
    drain();
    send_word(16'h02A5, 10, 1'b1);
    n_chk++; if (m_data !== 16'hFFA5) begin n_fail++; $display("FAIL t5_data: got %h need ffa5", m_data); end
    n_chk++; if (m_width !== 4'd8) begin n_fail++; $display("FAIL t5_width: got %0d need 8", m_width); end
    n_chk++; if (m_ovf !== 1'b1) begin n_fail++; $display("FAIL t5_ovf: got %b need 1", m_ovf); end
    send_word(16'h0080, 8, 1'b1);
    n_chk++; if (m_data !== 16'hFF80) begin n_fail++; $display("FAIL t5_full8: got %h need ff80", m_data); end
    n_chk++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL t5_ovf_clear: got %b need 0", m_ovf); end
    send_word(16'h0006, 3, 1'b0);
    n_chk++; if (m_data !== 16'h0006) begin n_fail++; $display("FAIL t5_after: got %h need 0006", m_data); end
    n_chk++; if (m_width !== 4'd3) begin n_fail++; $display("FAIL t5_after_width: got %0d need 3", m_width); end
  endtask

  task automatic test_mid_reset();
    drain();
    m_ready = 1'b0;
    send_word(16'h0001, 1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL t6_valid: got %b need 0", m_valid); end
    n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready: got %b need 1", s_ready); end
    n_chk++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL t6_data: got %h need 0000", m_data); end
    @(negedge clk);
    rst = 1'b0; m_ready = 1'b1;
    send_word(16'h0009, 4, 1'b1);
    n_chk++; if (m_data !== 16'hFFF9) begin n_fail++; $display("FAIL t6_next: got %h need fff9", m_data); end
    n_chk++; if (m_width !== 4'd4) begin n_fail++; $display("FAIL t6_next_width: got %0d need 4", m_width); end
    n_chk++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL t6_next_ovf: got %b need 0", m_ovf); end
  endtask

  task automatic test_back_to_back();
    drain();
    send_word(16'h0001, 1, 1'b0);
    n_chk++; if (m_data !== 16'h0001) begin n_fail++; $display("FAIL b2b_first: got %h need 0001", m_data); end
    send_word(16'h0001, 1, 1'b1);
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b need 1", m_valid); end
    n_chk++; if (m_data !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_second: got %h need ffff", m_data); end
  endtask

  initial begin
    test_reset();
    test_signed_one_bit();
    test_unsigned();
    test_signed_two_bit();
    test_stall();
    test_overflow();
    test_mid_reset();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
